// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - MMIO bridge between the core and the UART with RX/TX FIFOs and counters
module mmio_uart_ctrl #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int CNT_W    = 32,
  parameter int OFFSET_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                io_en,
  input  logic                io_we,
  input  logic [OFFSET_W-1:0] io_addr,
  input  logic [31:0]         io_wdata,
  output logic [31:0]         io_rdata,
  input  logic                inst_retire,
  input  logic [7:0]          uart_rx_data,
  input  logic                uart_rx_valid,
  output logic                uart_rx_ready,
  output logic [7:0]          uart_tx_data,
  output logic                uart_tx_valid,
  input  logic                uart_tx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [OFFSET_W-1:0] A_STATUS  = OFFSET_W'(8'h00);
  localparam logic [OFFSET_W-1:0] A_RX_DATA = OFFSET_W'(8'h04);
  localparam logic [OFFSET_W-1:0] A_TX_DATA = OFFSET_W'(8'h08);
  localparam logic [OFFSET_W-1:0] A_CYCLE   = OFFSET_W'(8'h10);
  localparam logic [OFFSET_W-1:0] A_INST    = OFFSET_W'(8'h14);
  localparam logic [OFFSET_W-1:0] A_CNT_RST = OFFSET_W'(8'h18);
  localparam logic [RX_AW:0]      RX_ONE    = (RX_AW+1)'(1);
  localparam logic [TX_AW:0]      TX_ONE    = (TX_AW+1)'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [RX_AW:0]   rx_wptr_q, rx_rptr_q, rx_count;
  logic [TX_AW:0]   tx_wptr_q, tx_rptr_q, tx_count;
  logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic [31:0]      io_rdata_q, rd_val;
  logic             rx_empty, rx_full, tx_empty, tx_full;
  logic             rx_push, rx_pop, tx_push, tx_pop, tx_wr, cnt_clr, rd_req;
  logic             unused_wdata;

  assign unused_wdata = ^io_wdata[31:8];

  assign rx_count = rx_wptr_q - rx_rptr_q;
  assign tx_count = tx_wptr_q - tx_rptr_q;
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                    (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                    (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);

  assign rd_req  = io_en && !io_we;
  assign rx_push = uart_rx_valid && !rx_full;
  assign rx_pop  = rd_req && (io_addr == A_RX_DATA) && !rx_empty;
  assign tx_wr   = io_en && io_we && (io_addr == A_TX_DATA);
  assign tx_pop  = !tx_empty && uart_tx_ready;
  // A drain in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign tx_push = tx_wr && (!tx_full || tx_pop);
  assign cnt_clr = io_en && io_we && (io_addr == A_CNT_RST);

  assign uart_rx_ready = !rx_full;
  assign uart_tx_valid = !tx_empty;
  assign uart_tx_data  = tx_mem_q[tx_rptr_q[TX_AW-1:0]];
  assign io_rdata      = io_rdata_q;

  always_comb begin
    cycle_d  = cnt_clr ? '0 : cycle_q + CNT_ONE;
    inst_d   = cnt_clr ? '0 : (inst_retire ? inst_q + CNT_ONE : inst_q);
    tx_ovf_d = cnt_clr ? 1'b0 : (tx_ovf_q || (tx_wr && !tx_push));
    rd_val   = '0;
    case (io_addr)
      A_STATUS:  rd_val = {8'h00, 8'(tx_count), 8'(rx_count), 5'b0, tx_ovf_q, !rx_empty, !tx_full};
      A_RX_DATA: rd_val = rx_empty ? 32'h0 : {24'h0, rx_mem_q[rx_rptr_q[RX_AW-1:0]]};
      A_CYCLE:   rd_val = 32'(cycle_q);
      A_INST:    rd_val = 32'(inst_q);
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= uart_rx_data;
    if (tx_push) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= io_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      cycle_q    <= '0;
      inst_q     <= '0;
      tx_ovf_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + RX_ONE;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + RX_ONE;
      if (tx_push) tx_wptr_q <= tx_wptr_q + TX_ONE;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TX_ONE;
      cycle_q  <= cycle_d;
      inst_q   <= inst_d;
      tx_ovf_q <= tx_ovf_d;
      if (rd_req) io_rdata_q <= rd_val;
    end
  end

endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
Memory-mapped I/O controller for the pipelined RISC-V core. It sits between the core's execute/memory-stage address path and the on-chip UART, and decouples them with parametrised RX and TX FIFOs. It also provides cycle and retired-instruction counters. Reads return one cycle after the request, so they line up with synchronous dmem/bios reads in the writeback mux.

Parameters:
RX_DEPTH, 8, RX FIFO entries; power of two, >= 2
TX_DEPTH, 8, TX FIFO entries; power of two, >= 2
CNT_W, 32, width of cycle and instruction counters (<= 32)
OFFSET_W, 8, number of low address bits decoded as register offset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
io_en  in  1  core request valid this cycle; caller decodes the I/O region
io_we  in  1  1 = store, 0 = load
io_addr  in  OFFSET_W  byte offset of register
io_wdata  in  32  store data
io_rdata  out  32  load data, valid the cycle after io_en && !io_we
inst_retire  in  1  pulse per retired instruction
uart_rx_data  in  8  byte from UART receiver
uart_rx_valid  in  1  receiver has a byte
uart_rx_ready  out  1  controller accepts byte (RX FIFO not full)
uart_tx_data  out  8  byte to UART transmitter
uart_tx_valid  out  1  TX FIFO not empty
uart_tx_ready  in  1  transmitter accepts byte

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On reset:
  - both FIFOs empty; all counters 0; overflow flag 0.
  - io_rdata = 0, uart_tx_valid = 0, uart_rx_ready = 1.
- Register map (offset, access):
  - 0x00 status (R): bit0 tx_not_full, bit1 rx_not_empty, bit2 tx_overflow (sticky), bits[15:8] RX occupancy, bits[23:16] TX occupancy, other bits 0.
  - 0x04 rx_data (R): {24'b0, head byte}; the read pops the RX FIFO.
  - 0x08 tx_data (W): pushes io_wdata[7:0] into the TX FIFO.
  - 0x10 cycle_count (R), zero-extended to 32.
  - 0x14 inst_count (R), zero-extended to 32.
  - 0x18 counter_reset (W, any data): clears both counters and the overflow flag.
- Unmapped offsets: reads return 0; writes have no effect.
- Read timing:
  - io_rdata is registered and reflects state sampled in the request cycle (pre-update).
  - io_rdata holds its value until the next read request.
- RX handshake: a byte transfers when uart_rx_valid && uart_rx_ready. uart_rx_ready = !rx_full, combinational from pointers.
- RX pop on empty: read of 0x04 when RX is empty returns 0 and does not pop; the pointers must not move.
- TX handshake:
  - a byte leaves when uart_tx_valid && uart_tx_ready.
  - uart_tx_data is the head entry.
  - uart_tx_valid = !tx_empty.
- TX overflow: a write to 0x08 when the TX FIFO is full drops the data and sets tx_overflow. The FIFO is unchanged.
- Simultaneous push and pop on either FIFO in the same cycle: both occur and occupancy is unchanged.
  - This applies even when the FIFO is full: a UART drain plus a core write in the same cycle is accepted, with no overflow.
  - When empty, only the push occurs.
- FIFO pointers:
  - $clog2(DEPTH)+1 bits wide; they wrap naturally.
  - full = MSBs differ and the remaining bits are equal.
  - Occupancy saturates only by construction (max DEPTH).
- cycle_count: increments every clock; wraps at 2^CNT_W-1 to 0.
- inst_count: increments on inst_retire; wraps identically.
- Counter reset collision: a counter_reset write takes priority over increment in that cycle; the value is 0 on the next cycle, not 1.
- Asserting rst mid-transfer discards FIFO contents immediately; no partial byte is presented after reset deassertion.

Test Plan:
1. Reset then read 0x00 -> io_rdata = 0x0000_0001 one cycle later; uart_rx_ready = 1; uart_tx_valid = 0.
2. Hold uart_tx_ready = 0; write 0x41..0x48 to 0x08 (8 writes), then write 0x49 -> status = 0x0008_0004 (TX occupancy 8, overflow set, tx_not_full 0). Then raise uart_tx_ready -> bytes 0x41..0x48 emitted in order; 0x49 is never emitted.
3. Drive RX bytes 0x10..0x18 back-to-back (9 offered) -> uart_rx_ready drops after the 8th accepted. Reads of 0x04 return 0x10..0x17. A further read returns 0 and the pointers are unchanged.
4. With TX full, same-cycle write 0x55 and uart_tx_ready = 1 -> occupancy stays 8, no overflow; 0x55 is emitted last.
5. Pulse inst_retire 5 times across 20 cycles, then read 0x14 -> 5. Write 0x18 -> cycle_count and inst_count read 0 on the next access.
6. Force cycle_count to 2^CNT_W-1 (CNT_W = 4 build) -> reads 0 after one more clock. Assert rst while TX is non-empty -> uart_tx_valid = 0 immediately (asynchronous).
